compare_pipe: RTL and testbench
===============================

// Module: compare_pipe
// PURPOSE
//   Registered, parametrised magnitude/equality comparator with valid/ready flow control.
//   Accepts operand pairs (a, b) and returns the eq, lt and gt flags plus a mode-selected result bit.
//   Keeps a saturating count of pairs whose selected result is 1.
//   Sits between an operand producer and a result consumer in datapath labs (search, sort, match units).
// PARAMETERS
//   WIDTH      8   operand width in bits (>=1)
//   SIGNED     0   0: unsigned compare; 1: two's-complement compare
//   CNT_WIDTH  8   width of the hit counter (>=1)
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous, active-high reset
//   in_valid   in   1          a/b/mode valid this cycle
//   in_ready   out  1          block can take a pair this cycle
//   a          in   WIDTH      operand A
//   b          in   WIDTH      operand B
//   mode       in   2          result select: 00 a==b, 01 a!=b, 10 a<b, 11 a>b
//   out_valid  out  1          result registers hold an undelivered result
//   out_ready  in   1          consumer takes the result this cycle
//   res        out  1          mode-selected result
//   eq         out  1          a==b
//   lt         out  1          a<b (signedness per SIGNED)
//   gt         out  1          a>b (signedness per SIGNED)
//   clr_cnt    in   1          synchronous clear of hit_cnt
//   hit_cnt    out  CNT_WIDTH  number of accepted pairs with res==1, saturating
// BEHAVIOUR
//   Reset (async, rst=1): out_valid=0, res=0, eq=0, lt=0, gt=0, hit_cnt=0. State is EMPTY.
//   The state machine has two states.
//     EMPTY: out_valid=0.
//     FULL:  out_valid=1.
//   Handshake:
//     in_ready = !out_valid || out_ready (combinational; pass-through allowed).
//     accept = in_valid && in_ready. deliver = out_valid && out_ready.
//   Transitions:
//     EMPTY -> FULL on accept.
//     FULL -> FULL on accept && deliver (back-to-back: one result per cycle).
//     FULL -> EMPTY on deliver && !accept.
//     FULL holds while !out_ready. res/eq/lt/gt stay stable until delivered.
//   Latency: 1 cycle. A pair accepted at edge N has its result visible after edge N with out_valid=1.
//   Result registers load only on accept. Exactly one of eq/lt/gt is 1 for every loaded result.
//   Results are computed on the full WIDTH bits.
//     SIGNED=1 interprets the MSB as the sign bit.
//     WIDTH=1 with SIGNED=1 gives a range of {-1, 0}.
//   Hit counter:
//     Increments on an accept whose computed res is 1.
//     Saturates at 2^CNT_WIDTH-1; it never wraps.
//     clr_cnt=1 sets hit_cnt to 0 at the next edge and wins over a simultaneous increment (that hit is lost).
//     clr_cnt has no effect on out_valid or the result registers.
//   mode is sampled only on accept. Changing mode while FULL does not alter the held res.
//   An assertion of rst mid-operation discards any held result at once.
//     out_valid drops with no delivery.
//     The first accept after release behaves as from a fresh reset.
//   in_valid with X operands is not accepted while in_ready=0. Operands are not required to be held after accept.
// TESTING
//   T1 reset: rst pulse mid-run with out_valid=1 -> out_valid, res, eq, lt, gt and hit_cnt read 0 immediately; in_ready=1.
//   T2 basic (WIDTH=8, SIGNED=0):
//      a=8'h3C, b=8'h3C, mode=00 -> next cycle out_valid=1, res=1, eq=1, hit_cnt=1.
//      a=8'h10, b=8'h20, mode=11 -> res=0, lt=1, hit_cnt stays 1.
//   T3 signedness:
//      a=8'h80, b=8'h01, mode=10 -> SIGNED=0: res=0, gt=1.
//      a=8'h80, b=8'h01, mode=10 -> SIGNED=1: res=1, lt=1.
//   T4 backpressure: hold out_ready=0 with in_valid=1 -> in_ready=0, res/eq/lt/gt frozen for 5 cycles, no extra hit counted.
//      Then raise out_ready -> one delivery per cycle with no bubbles.
//   T5 throughput: 16 back-to-back pairs with out_ready=1 -> 16 results on consecutive cycles, in order.
//   T6 counter (CNT_WIDTH=2):
//      Five matching pairs -> hit_cnt saturates at 3.
//      clr_cnt=1 on the same cycle as a matching accept -> hit_cnt=0 the next cycle.

Source files
------------

// File: rtl/compare_pipe.sv
// rtl/compare_pipe.sv - registered magnitude/equality comparator with valid/ready handshake
// and a saturating hit counter.
module compare_pipe #(
   parameter int WIDTH     = 8,
   parameter int SIGNED    = 0,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 res,
   output logic                 eq,
   output logic                 lt,
   output logic                 gt,
   input  logic                 clr_cnt,
   output logic [CNT_WIDTH-1:0] hit_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   localparam logic [WIDTH-1:0] FLIP = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

   state_t state, state_next;
   logic   accept, deliver;
   logic   c_eq, c_lt, c_gt, c_res;

   assign out_valid = (state == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign deliver   = out_valid && out_ready;

   always_comb begin
      c_eq  = (a == b);
      c_lt  = ((a ^ FLIP) < (b ^ FLIP));
      c_gt  = !c_eq && !c_lt;
      c_res = 1'b0;
      case (mode)
         2'b00:   c_res = c_eq;
         2'b01:   c_res = !c_eq;
         2'b10:   c_res = c_lt;
         default: c_res = c_gt;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (accept) state_next = FULL;
         FULL:    if (deliver && !accept) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res <= 1'b0;
         eq  <= 1'b0;
         lt  <= 1'b0;
         gt  <= 1'b0;
      end else if (accept) begin
         res <= c_res;
         eq  <= c_eq;
         lt  <= c_lt;
         gt  <= c_gt;
      end
   end

   // Clear has priority; a hit landing on the clearing edge is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     hit_cnt <= '0;
      else if (clr_cnt)                            hit_cnt <= '0;
      else if (accept && c_res && hit_cnt != '1)   hit_cnt <= hit_cnt + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_compare_pipe.sv
// tb/tb_compare_pipe.sv - scoreboard bench for compare_pipe: unsigned reference instance plus
// signed and narrow-counter instances sharing the same stimulus.
module tb_compare_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       clr_cnt = 1'b0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic [1:0] mode = 2'b00;

   logic       m_in_ready, m_out_valid, m_res, m_eq, m_lt, m_gt;
   logic [7:0] m_hit_cnt;
   logic       s_in_ready, s_out_valid, s_res, s_eq, s_lt, s_gt;
   logic [7:0] s_hit_cnt;
   logic       c_in_ready, c_out_valid, c_res, c_eq, c_lt, c_gt;
   logic [1:0] c_hit_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] sb_q[$];
   int         exp_hits = 0;
   logic       exp_ready;

   always #5 clk = ~clk;

   compare_pipe #(.WIDTH(8), .SIGNED(0), .CNT_WIDTH(8)) u_main (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .a(a), .b(b),
      .mode(mode), .out_valid(m_out_valid), .out_ready(out_ready), .res(m_res), .eq(m_eq),
      .lt(m_lt), .gt(m_gt), .clr_cnt(clr_cnt), .hit_cnt(m_hit_cnt));

   compare_pipe #(.WIDTH(8), .SIGNED(1), .CNT_WIDTH(8)) u_sgn (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
      .mode(mode), .out_valid(s_out_valid), .out_ready(out_ready), .res(s_res), .eq(s_eq),
      .lt(s_lt), .gt(s_gt), .clr_cnt(clr_cnt), .hit_cnt(s_hit_cnt));

   compare_pipe #(.WIDTH(8), .SIGNED(0), .CNT_WIDTH(2)) u_cnt (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .a(a), .b(b),
      .mode(mode), .out_valid(c_out_valid), .out_ready(out_ready), .res(c_res), .eq(c_eq),
      .lt(c_lt), .gt(c_gt), .clr_cnt(clr_cnt), .hit_cnt(c_hit_cnt));

   // Unsigned reference result, packed {res, eq, lt, gt}.
   function automatic logic [3:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] m);
      int  xi, yi;
      logic r;
      xi = int'(x);
      yi = int'(y);
      case (m)
         2'b00:   r = (xi == yi);
         2'b01:   r = (xi != yi);
         2'b10:   r = (xi <  yi);
         default: r = (xi >  yi);
      endcase
      return {r, xi == yi, xi < yi, xi > yi};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: checks the main instance every falling edge, then models the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         exp_hits = 0;
      end else begin
         exp_ready = (sb_q.size() == 0) || out_ready;
         chk("out_valid", {31'd0, m_out_valid}, {31'd0, sb_q.size() != 0});
         chk("in_ready", {31'd0, m_in_ready}, {31'd0, exp_ready});
         chk("hit_cnt", {24'd0, m_hit_cnt}, exp_hits);
         chk("sgn_lockstep", {31'd0, s_out_valid}, {31'd0, sb_q.size() != 0});
         if (sb_q.size() != 0) begin
            chk("result", {28'd0, m_res, m_eq, m_lt, m_gt}, {28'd0, sb_q[0]});
            if (out_ready) void'(sb_q.pop_front());
         end
         if (in_valid && exp_ready) begin
            sb_q.push_back(model(a, b, mode));
            if (!clr_cnt && model(a, b, mode)[3] && exp_hits < 255) exp_hits++;
         end
         if (clr_cnt) exp_hits = 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y,
                        input logic [1:0] m);
      in_valid = v;
      a        = x;
      b        = y;
      mode     = m;
   endtask

   initial begin
      // Power-on reset
      repeat (2) cyc();
      chk("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
      chk("rst_hit_cnt", {24'd0, m_hit_cnt}, 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      cyc();

      // Basic unsigned compare
      drive(1'b1, 8'h3C, 8'h3C, 2'b00);
      cyc();
      chk("t2_valid", {31'd0, m_out_valid}, 32'd1);
      chk("t2_res_eq", {30'd0, m_res, m_eq}, 32'd3);
      chk("t2_hit1", {24'd0, m_hit_cnt}, 32'd1);
      drive(1'b1, 8'h10, 8'h20, 2'b11);
      cyc();
      chk("t2b_res_lt", {29'd0, m_res, m_lt, m_gt}, 32'b010);
      chk("t2b_hit", {24'd0, m_hit_cnt}, 32'd1);

      // Signedness: same pair through unsigned and signed instances
      drive(1'b1, 8'h80, 8'h01, 2'b10);
      cyc();
      chk("t3_unsigned", {29'd0, m_res, m_lt, m_gt}, 32'b001);
      chk("t3_signed", {29'd0, s_res, s_lt, s_gt}, 32'b110);
      drive(1'b1, 8'hFF, 8'h00, 2'b11);
      cyc();
      chk("t3_signed_neg1", {29'd0, s_res, s_lt, s_gt}, 32'b010);
      drive(1'b0, 8'h00, 8'h00, 2'b00);
      cyc();

      // Backpressure: one result held, next pair blocked for 5 cycles
      out_ready = 1'b0;
      drive(1'b1, 8'h05, 8'h09, 2'b10);
      cyc();
      drive(1'b1, 8'h44, 8'h44, 2'b00);
      for (int i = 0; i < 5; i++) begin
         cyc();
         mode = 2'(i);
         chk("t4_in_ready_low", {31'd0, m_in_ready}, 32'd0);
         chk("t4_frozen", {28'd0, m_res, m_eq, m_lt, m_gt}, 32'b1010);
      end
      mode = 2'b00;
      out_ready = 1'b1;
      cyc();
      drive(1'b1, 8'h90, 8'h12, 2'b11);
      cyc();
      drive(1'b1, 8'h01, 8'h01, 2'b01);
      cyc();
      drive(1'b0, 8'h00, 8'h00, 2'b00);
      cyc();
      cyc();

      // Throughput: 16 back-to-back random pairs
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               2'($urandom_range(0, 3)));
         if (i % 5 == 0) b = a;
         cyc();
         chk("t5_streaming", {31'd0, m_out_valid}, 32'd1);
      end
      drive(1'b0, 8'h00, 8'h00, 2'b00);
      cyc();

      // Random flow control
      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)));
         out_ready = 1'($urandom_range(0, 1));
         clr_cnt   = ($urandom_range(0, 19) == 0);
         cyc();
      end
      clr_cnt = 1'b0;
      in_valid = 1'b0;

      // Reset mid-run with a held result
      out_ready = 1'b0;
      drive(1'b1, 8'h07, 8'h07, 2'b00);
      cyc();
      in_valid = 1'b0;
      chk("t1_pre_valid", {31'd0, m_out_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("t1_out_valid", {31'd0, m_out_valid}, 32'd0);
      chk("t1_flags", {28'd0, m_res, m_eq, m_lt, m_gt}, 32'd0);
      chk("t1_hit_cnt", {24'd0, m_hit_cnt}, 32'd0);
      chk("t1_in_ready", {31'd0, m_in_ready}, 32'd1);
      cyc();
      rst = 1'b0;
      out_ready = 1'b1;
      cyc();

      // Counter saturation on the 2-bit instance
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'(i * 3), 8'(i * 3), 2'b00);
         cyc();
         chk("t6_count", {30'd0, c_hit_cnt}, (i < 3) ? i + 1 : 3);
      end
      clr_cnt = 1'b1;
      drive(1'b1, 8'h22, 8'h22, 2'b00);
      cyc();
      clr_cnt = 1'b0;
      chk("t6_clear_wins", {30'd0, c_hit_cnt}, 32'd0);
      chk("t6_clear_keeps_valid", {31'd0, c_out_valid}, 32'd1);
      chk("t6_clear_keeps_res", {31'd0, c_res}, 32'd1);
      drive(1'b0, 8'h00, 8'h00, 2'b00);

      // Drain
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc();
      cyc();
      chk("drained", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
